// File: rtl/mips_datapath_pc_sequencer_pkg.sv
// Shared types for the PC sequencer: decoded PC action encoding and jump-field geometry.
package Mips_Datapath_Pc_Sequencer_Types;

  localparam int ACTION_W        = 3;
  localparam int JUMP_REGION_LSB = 28;
  localparam int JUMP_FIELD_LSB  = 2;

  typedef enum logic [ACTION_W-1:0] {
    ACT_NEXT   = 3'd0,
    ACT_BRANCH = 3'd1,
    ACT_JUMP   = 3'd2,
    ACT_JUMPR  = 3'd3,
    ACT_RETURN = 3'd4
  } pc_action_e;

  // Actions that may carry a link (call) and therefore push a return address.
  function automatic logic is_link_action(input logic [ACTION_W-1:0] action);
    return (action == ACT_JUMP) || (action == ACT_JUMPR) || (action == ACT_RETURN);
  endfunction

endpackage

// File: rtl/mips_datapath_pc_sequencer_if.sv
// Decode/fetch-side bundle of the PC sequencer; master drives the decoded controls, slave is the sequencer.
interface mips_datapath_pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  import Mips_Datapath_Pc_Sequencer_Types::*;

  logic                stall;
  logic [ACTION_W-1:0] action;
  logic                link;
  logic [15:0]         offset;
  logic [25:0]         jump;
  logic [ADDR_W-1:0]   jumpr;
  logic                redirect;
  logic [ADDR_W-1:0]   redirectAddr;
  logic [ADDR_W-1:0]   addrCurr;
  logic [ADDR_W-1:0]   addrNext;
  logic                rasEmpty;
  logic                rasFull;

  modport master (
    output stall, action, link, offset, jump, jumpr, redirect, redirectAddr,
    input  addrCurr, addrNext, rasEmpty, rasFull
  );

  modport slave (
    input  stall, action, link, offset, jump, jumpr, redirect, redirectAddr,
    output addrCurr, addrNext, rasEmpty, rasFull
  );

endinterface

// File: rtl/mips_datapath_pc_ras.sv
// Circular return address stack: top pointer plus occupancy count; a push when full overwrites the oldest entry.
module mips_datapath_pc_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] pushData_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_idx_s;

  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == CNT_W'(0));
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));

  // Pointer/count next state; pop+push on a non-empty stack rewrites the top in place.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (push_i && pop_i && !empty_o) begin
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q;
    end else if (push_i) begin
      ptr_d    = ptr_q + PTR_W'(1);
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q + PTR_W'(1);
      if (!full_o) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents after reset are irrelevant because the count gates them.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !rst_i) begin
      mem_q[wr_idx_s] <= pushData_i;
    end
  end

endmodule

// File: rtl/mips_datapath_pc_sequencer.sv
// PC sequencer at the head of fetch: next-PC selection with redirect/stall and optional RAS return prediction.
// The return address stack is built only when MIPS_DATAPATH_PC_RAS_EN is defined.
module mips_datapath_pc_sequencer
  import Mips_Datapath_Pc_Sequencer_Types::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic clock,
  input  logic reset,
  mips_datapath_pc_sequencer_if.slave bus
);

  if (ADDR_W < JUMP_REGION_LSB) begin : g_bad_addr_w
    $error("ADDR_W must be at least 28");
  end
  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two, at least 2");
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] seq_s, branch_tgt_s, jump_tgt_s, ret_tgt_s, action_tgt_s;

  assign seq_s        = addr_q + ADDR_W'(3'd4);
  assign branch_tgt_s = seq_s + {{(ADDR_W-18){bus.offset[15]}}, bus.offset, 2'b00};

  // Jump keeps the 256 MB region of the sequential address; no region bits exist at ADDR_W == 28.
  if (ADDR_W > JUMP_REGION_LSB) begin : g_jump_region
    assign jump_tgt_s = {seq_s[ADDR_W-1:JUMP_REGION_LSB], bus.jump, {JUMP_FIELD_LSB{1'b0}}};
  end else begin : g_jump_flat
    assign jump_tgt_s = {bus.jump, {JUMP_FIELD_LSB{1'b0}}};
  end

`ifdef MIPS_DATAPATH_PC_RAS_EN
  logic              push_s, pop_s, ras_empty_s, ras_full_s;
  logic [ADDR_W-1:0] ras_top_s;

  // The stack only moves on a cycle that actually advances the PC along the decoded path.
  assign pop_s  = (bus.action == ACT_RETURN) && !bus.stall && !bus.redirect;
  assign push_s = bus.link && is_link_action(bus.action) && !bus.stall && !bus.redirect;

  mips_datapath_pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .pushData_i (seq_s),
    .top_o      (ras_top_s),
    .empty_o    (ras_empty_s),
    .full_o     (ras_full_s)
  );

  assign ret_tgt_s    = ras_empty_s ? bus.jumpr : ras_top_s;
  assign bus.rasEmpty = ras_empty_s;
  assign bus.rasFull  = ras_full_s;
`else
  assign ret_tgt_s    = bus.jumpr;
  assign bus.rasEmpty = 1'b1;
  assign bus.rasFull  = 1'b0;
`endif

  // Target of the decoded action; unused encodings fall through as sequential.
  always_comb begin
    action_tgt_s = seq_s;
    case (bus.action)
      ACT_BRANCH: action_tgt_s = branch_tgt_s;
      ACT_JUMP:   action_tgt_s = jump_tgt_s;
      ACT_JUMPR:  action_tgt_s = bus.jumpr;
      ACT_RETURN: action_tgt_s = ret_tgt_s;
      default:    action_tgt_s = seq_s;
    endcase
  end

  // Next-PC priority: reset, then execute redirect, then stall hold, then the action target.
  always_comb begin
    addr_d = action_tgt_s;
    if (reset) begin
      addr_d = RESET_ADDR;
    end else if (bus.redirect) begin
      addr_d = bus.redirectAddr;
    end else if (bus.stall) begin
      addr_d = addr_q;
    end else begin
      addr_d = action_tgt_s;
    end
  end

  // Fetch address register.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= RESET_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign bus.addrCurr = addr_q;
  assign bus.addrNext = addr_d;

endmodule

// File: doc/mips_datapath_pc_sequencer.md
# mips_datapath_pc_sequencer

Parametrised program-counter sequencer: next generation of the PC datapath, generalised in address width and reset vector, with pipeline stall, execute-stage redirect and a configurable-depth return address stack (RAS) that predicts `jr $ra` targets. Sits at the head of the fetch stage. Consumes the decoded PC action, immediate fields and register port 1. Drives the fetch address and the next-address preview.

## Interface
Parameters:
- ADDR_W, 32, address width; must be ≥ 28.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥ 2.
- RESET_ADDR, 0, value loaded into addrCurr on reset.

Ports:
- ctrl.clock  input  1  clock; all state changes on the rising edge.
- ctrl.reset  input  1  reset; synchronous, active-high.
- stall  input  1  hold the PC and RAS this cycle.
- action  input  3  Next=0, Branch=1, Jump=2, JumpR=3, Return=4; 5–7 behave as Next.
- link  input  1  push a link address this cycle; valid with Jump or JumpR.
- offset  input  16  I-format immediate.
- jump  input  26  J-format target.
- jumpr  input  ADDR_W  register port 1 value.
- redirect  input  1  execute-stage correction; highest priority.
- redirectAddr  input  ADDR_W  corrected target.
- addrCurr  output  ADDR_W  registered fetch address.
- addrNext  output  ADDR_W  combinational value addrCurr loads on the next edge.
- rasEmpty  output  1  RAS count == 0.
- rasFull  output  1  RAS count == RAS_DEPTH.

## Operation
- seq = addrCurr + 4, truncated to ADDR_W.
- Next: seq.
- Branch: seq + (sign-extended offset << 2), mod 2^ADDR_W.
- Jump: {seq[ADDR_W-1:28], jump, 2'b00}.
- JumpR: jumpr.
- Return: RAS top when non-empty, else jumpr.
- Priority for addrNext: reset → RESET_ADDR; redirect → redirectAddr; stall → addrCurr; otherwise the action target.
- RAS is circular, with a top pointer and a count.
- Push (link=1 with action Jump or JumpR, no stall, no redirect): writes seq.
  - When full, push overwrites the oldest entry. Pointer wraps; count stays RAS_DEPTH.
- Pop (action Return, no stall, no redirect): decrements count.
  - Pop on empty: no state change, target falls back to jumpr.
- Return with link=1: pop then push in the same cycle. Top entry is replaced by seq; count unchanged.
- link with Next or Branch: ignored.
- Stall and redirect leave the RAS unchanged.
- Reset: count 0, pointer 0, addrCurr=RESET_ADDR, rasEmpty=1, rasFull=0. Entry contents are don't-care.
- Reset mid-stall or mid-redirect: reset wins.

## Timing
- addrCurr updates one edge after addrNext is presented. Zero-cycle combinational path from inputs to addrNext.
- A RAS push is visible to a Return in the following cycle. There is no same-cycle bypass, except the Return+link case above.
- redirect asserted during stall takes effect at the same edge.
- rasEmpty and rasFull are registered-state derived and valid the cycle after the update.

## Configuration
- MIPS_DATAPATH_PC_RAS_EN defined: RAS instantiated as above.
- Undefined: no RAS storage. Return behaves exactly as JumpR, link is ignored, rasEmpty is tied 1 and rasFull is tied 0.

## Structure
- Shared package Mips_Datapath_Pc_Sequencer_Types:
  - action enum and its width.
  - Next=0…Return=4 constants.
  - jump-field bit positions (28, 2).
- Sub-module mips_datapath_pc_ras, parameters ADDR_W and RAS_DEPTH:
  - inputs push, pop, pushData.
  - outputs top, empty, full.
  - compiled in only under MIPS_DATAPATH_PC_RAS_EN.

## Test plan
- Reset with RESET_ADDR=0x400000, then Next ×3 → addrCurr 0x400000, 0x400004, 0x400008, 0x40000C.
- addrCurr=0x1000, Branch offset=0xFFFF → addrNext 0x1000. Branch offset=0x0010 → 0x1044.
- addrCurr=0x1000, Jump link=1 jump=0x0000100, then Return with jumpr=0xDEAD → PC 0x400, then 0x1004; rasEmpty back to 1.
- RAS_DEPTH=4, five pushes of seq values A..E, then five Returns with jumpr=0x9000 → E, D, C, B, then 0x9000. rasFull=1 after the 4th push.
- Stall and redirect=1 redirectAddr=0x2000 in the same cycle with action Return, RAS non-empty → addrCurr 0x2000, RAS count unchanged.
- Build without MIPS_DATAPATH_PC_RAS_EN: Jump link=1, then Return with jumpr=0x3000 → 0x3000; rasEmpty=1 throughout.
